// File: rtl/ncl_pkg.sv
// Shared dual-rail (NULL convention logic) encodings, opcodes, FSM states and
// bus helpers used by the digit-serial ALU.
package ncl_pkg;

    localparam logic [1:0] NCL_NULL = 2'b00;
    localparam logic [1:0] NCL_D0   = 2'b01;
    localparam logic [1:0] NCL_D1   = 2'b10;
    localparam logic [1:0] NCL_ILL  = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    // Widest bus the helpers accept; callers zero-extend (pad with NULL pairs).
    localparam int NCL_MAXW = 64;

    typedef enum logic [1:0] {
        WAIT_DATA = 2'd0,
        COMPUTE   = 2'd1,
        OUT_DATA  = 2'd2,
        OUT_NULL  = 2'd3
    } state_t;

    // True when the low n pairs all carry DATA0 or DATA1.
    function automatic logic ncl_all_data(input logic [2*NCL_MAXW-1:0] x, input int n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NCL_MAXW; i++) begin
            if (i < n && (x[2*i +: 2] == NCL_NULL || x[2*i +: 2] == NCL_ILL))
                ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic ncl_all_null(input logic [2*NCL_MAXW-1:0] x);
        return (x == '0);
    endfunction

    function automatic logic ncl_any_ill(input logic [2*NCL_MAXW-1:0] x);
        logic ill;
        ill = 1'b0;
        for (int i = 0; i < NCL_MAXW; i++) begin
            if (x[2*i +: 2] == NCL_ILL)
                ill = 1'b1;
        end
        return ill;
    endfunction

    // Encodes the low n bits as DATA pairs; pairs above n stay NULL.
    function automatic logic [2*NCL_MAXW-1:0] ncl_enc(input logic [NCL_MAXW-1:0] v, input int n);
        logic [2*NCL_MAXW-1:0] x;
        x = '0;
        for (int i = 0; i < NCL_MAXW; i++) begin
            if (i < n)
                x[2*i +: 2] = v[i] ? NCL_D1 : NCL_D0;
        end
        return x;
    endfunction

    // Only meaningful on complete DATA: the true rail of each pair is the bit.
    function automatic logic [NCL_MAXW-1:0] ncl_dec(input logic [2*NCL_MAXW-1:0] x);
        logic [NCL_MAXW-1:0] v;
        v = '0;
        for (int i = 0; i < NCL_MAXW; i++)
            v[i] = x[2*i+1];
        return v;
    endfunction

endpackage

// File: rtl/ncl_alu_digit.sv
// Combinational DIGIT-bit ALU slice. Exposes the carry into its MSB so the
// final digit can derive signed overflow.
module ncl_alu_digit
    import ncl_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic [1:0]       op,
    input  logic             ci,
    output logic [DIGIT-1:0] r,
    output logic             co,
    output logic             cm
);

    logic [DIGIT-1:0] bx;
    logic [DIGIT-1:0] sum;
    logic             cc;

    always_comb begin
        bx  = (op == OP_SUB) ? ~b : b;
        sum = '0;
        cc  = ci;
        cm  = ci;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1)
                cm = cc;
            sum[i] = a[i] ^ bx[i] ^ cc;
            cc     = (a[i] & bx[i]) | (a[i] & cc) | (bx[i] & cc);
        end
        co = cc;
        case (op)
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            default: r = sum;
        endcase
    end

endmodule

// File: rtl/ncl_alu_seq.sv
// Digit-serial dual-rail ALU wrapped in a clocked four-phase NULL/DATA
// wavefront handshake; one DIGIT-bit slice is reused WIDTH/DIGIT times.
module ncl_alu_seq
    import ncl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*WIDTH-1:0] a,
    input  logic [2*WIDTH-1:0] b,
    input  logic [3:0]         opr,
    input  logic               ki,
    output logic               ko,
    output logic [2*WIDTH-1:0] soma,
    output logic [1:0]         of,
    output logic [1:0]         zero,
    output logic [1:0]         neg,
    output logic               err
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    generate
        if (DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("ncl_alu_seq: WIDTH must be a multiple of DIGIT");
        end
        if (WIDTH > NCL_MAXW) begin : g_bad_width
            $error("ncl_alu_seq: WIDTH exceeds NCL_MAXW");
        end
    endgenerate

    // Handshake: ko=1 asks upstream for DATA, ko=0 asks for NULL. A DATA
    // wavefront is taken only when every input pair is DATA and ko=1; the
    // result is held as DATA until ki=0, and the next DATA is accepted only
    // after ki=1 and a full NULL wavefront on the inputs.
    state_t           state, state_n;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [1:0]       op_r;
    logic             carry;
    logic             ovf_r;
    logic [CW-1:0]    cnt;

    logic             in_data, in_null, in_ill;
    logic [DIGIT-1:0] d_res;
    logic             d_co, d_cm;

    assign in_data = ncl_all_data((2*NCL_MAXW)'(a), WIDTH)
                   & ncl_all_data((2*NCL_MAXW)'(b), WIDTH)
                   & ncl_all_data((2*NCL_MAXW)'(opr), 2);
    assign in_null = ncl_all_null((2*NCL_MAXW)'(a))
                   & ncl_all_null((2*NCL_MAXW)'(b))
                   & ncl_all_null((2*NCL_MAXW)'(opr));
    assign in_ill  = ncl_any_ill((2*NCL_MAXW)'(a))
                   | ncl_any_ill((2*NCL_MAXW)'(b))
                   | ncl_any_ill((2*NCL_MAXW)'(opr));

    ncl_alu_digit #(.DIGIT(DIGIT)) u_digit (
        .a  (a_sr[DIGIT-1:0]),
        .b  (b_sr[DIGIT-1:0]),
        .op (op_r),
        .ci (carry),
        .r  (d_res),
        .co (d_co),
        .cm (d_cm)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= WAIT_DATA;
        else
            state <= state_n;
    end

    // COMPUTE runs NDIG digit cycles plus one cycle to load the output word.
    always_comb begin
        state_n = state;
        case (state)
            WAIT_DATA: if (!in_ill && in_data)     state_n = COMPUTE;
            COMPUTE:   if (cnt == CW'(NDIG))       state_n = OUT_DATA;
            OUT_DATA:  if (!ki)                    state_n = OUT_NULL;
            OUT_NULL:  if (ki && in_null)          state_n = WAIT_DATA;
            default:                               state_n = WAIT_DATA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            op_r   <= OP_ADD;
            carry  <= 1'b0;
            ovf_r  <= 1'b0;
            cnt    <= '0;
            ko     <= 1'b1;
            soma   <= '0;
            of     <= NCL_NULL;
            zero   <= NCL_NULL;
            neg    <= NCL_NULL;
            err    <= 1'b0;
        end else begin
            ko <= (state_n == WAIT_DATA);
            case (state)
                WAIT_DATA: begin
                    if (in_ill) begin
                        err <= 1'b1;
                    end else if (in_data) begin
                        a_sr  <= WIDTH'(ncl_dec((2*NCL_MAXW)'(a)));
                        b_sr  <= WIDTH'(ncl_dec((2*NCL_MAXW)'(b)));
                        op_r  <= 2'(ncl_dec((2*NCL_MAXW)'(opr)));
                        carry <= (2'(ncl_dec((2*NCL_MAXW)'(opr))) == OP_SUB);
                        cnt   <= '0;
                    end
                end
                COMPUTE: begin
                    if (cnt != CW'(NDIG)) begin
                        a_sr   <= a_sr >> DIGIT;
                        b_sr   <= b_sr >> DIGIT;
                        res_sr <= (res_sr >> DIGIT) | (WIDTH'(d_res) << (WIDTH - DIGIT));
                        carry  <= d_co;
                        cnt    <= cnt + CW'(1);
                        if (cnt == CW'(NDIG - 1))
                            ovf_r <= ~op_r[1] & (d_cm ^ d_co);
                    end else begin
                        // Whole output word flips to DATA on a single edge.
                        soma <= (2*WIDTH)'(ncl_enc(NCL_MAXW'(res_sr), WIDTH));
                        of   <= ovf_r ? NCL_D1 : NCL_D0;
                        zero <= (res_sr == '0) ? NCL_D1 : NCL_D0;
                        neg  <= res_sr[WIDTH-1] ? NCL_D1 : NCL_D0;
                    end
                end
                OUT_DATA: begin
                    if (!ki) begin
                        soma <= '0;
                        of   <= NCL_NULL;
                        zero <= NCL_NULL;
                        neg  <= NCL_NULL;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ncl_alu_seq.sv
// Directed bench for ncl_alu_seq: three instances (4/1, 8/4, 8/2) share a
// clock and reset; expected words are hand-computed binary, dual-rail encoded.
module tb_ncl_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a_v   [3];
    logic [15:0] b_v   [3];
    logic [3:0]  opr_v [3];
    logic        ki_v  [3];
    logic        ko_v  [3];
    logic [15:0] soma_v[3];
    logic [7:0]  soma0;
    logic [1:0]  of_v  [3];
    logic [1:0]  zero_v[3];
    logic [1:0]  neg_v [3];
    logic        err_v [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign soma_v[0] = {8'h00, soma0};

    ncl_alu_seq #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
        .clk(clk), .rst(rst), .a(a_v[0][7:0]), .b(b_v[0][7:0]), .opr(opr_v[0]),
        .ki(ki_v[0]), .ko(ko_v[0]), .soma(soma0), .of(of_v[0]),
        .zero(zero_v[0]), .neg(neg_v[0]), .err(err_v[0])
    );

    ncl_alu_seq #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst(rst), .a(a_v[1]), .b(b_v[1]), .opr(opr_v[1]),
        .ki(ki_v[1]), .ko(ko_v[1]), .soma(soma_v[1]), .of(of_v[1]),
        .zero(zero_v[1]), .neg(neg_v[1]), .err(err_v[1])
    );

    ncl_alu_seq #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
        .clk(clk), .rst(rst), .a(a_v[2]), .b(b_v[2]), .opr(opr_v[2]),
        .ki(ki_v[2]), .ko(ko_v[2]), .soma(soma_v[2]), .of(of_v[2]),
        .zero(zero_v[2]), .neg(neg_v[2]), .err(err_v[2])
    );

    localparam logic [1:0] D0 = 2'b01;
    localparam logic [1:0] D1 = 2'b10;

    function automatic logic [15:0] enc(input logic [7:0] v, input int w);
        logic [15:0] x;
        x = '0;
        for (int i = 0; i < w; i++)
            x[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        return x;
    endfunction

    function automatic int wid(input int d);
        return (d == 0) ? 4 : 8;
    endfunction

    // Posedges from the driving negedge until the first DATA sample: N+2.
    function automatic int lat(input int d);
        return (d == 0) ? 6 : (d == 1) ? 4 : 6;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                            input logic [1:0] op);
        logic [15:0] t;
        t         = enc({6'b0, op}, 2);
        a_v[d]    = enc(av, wid(d));
        b_v[d]    = enc(bv, wid(d));
        opr_v[d]  = t[3:0];
        ki_v[d]   = 1'b1;
    endtask

    task automatic wait_result(input int d, input string tag, input logic [7:0] es,
                               input logic [1:0] eof, input logic [1:0] ez,
                               input logic [1:0] en);
        int cyc;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, "_ko_busy"}, 32'(ko_v[d]), 32'd0);
            if (of_v[d] != 2'b00) break;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(lat(d)));
        check({tag, "_soma"}, 32'(soma_v[d]), 32'(enc(es, wid(d))));
        check({tag, "_flags"}, {26'd0, eof, ez, en}, {26'd0, eof, ez, en} == 0 ? 32'hx :
              {26'd0, of_v[d], zero_v[d], neg_v[d]} == 0 ? 32'h1 : {26'd0, eof, ez, en});
        check({tag, "_of"},   32'(of_v[d]),   32'(eof));
        check({tag, "_zero"}, 32'(zero_v[d]), 32'(ez));
        check({tag, "_neg"},  32'(neg_v[d]),  32'(en));
    endtask

    task automatic release_op(input int d, input string tag);
        a_v[d]   = '0;
        b_v[d]   = '0;
        opr_v[d] = '0;
        ki_v[d]  = 1'b0;
        @(negedge clk);
        check({tag, "_null_out"}, {10'd0, soma_v[d], of_v[d], zero_v[d], neg_v[d]}, 32'd0);
        check({tag, "_ko_null"}, 32'(ko_v[d]), 32'd0);
        ki_v[d] = 1'b1;
        @(negedge clk);
        check({tag, "_ko_ready"}, 32'(ko_v[d]), 32'd1);
    endtask

    task automatic full_op(input int d, input string tag, input logic [7:0] av,
                           input logic [7:0] bv, input logic [1:0] op, input logic [7:0] es,
                           input logic [1:0] eof, input logic [1:0] ez, input logic [1:0] en);
        start_op(d, av, bv, op);
        wait_result(d, tag, es, eof, ez, en);
        release_op(d, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            a_v[d] = '0; b_v[d] = '0; opr_v[d] = '0; ki_v[d] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_out", {10'd0, soma_v[d], of_v[d], zero_v[d], neg_v[d]}, 32'd0);
            check("rst_ko", 32'(ko_v[d]), 32'd1);
            check("rst_err", 32'(err_v[d]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // 4-bit serial add: 5+3 = 8 overflows into the sign bit.
        full_op(0, "add4", 8'h5, 8'h3, 2'b00, 8'h8, D1, D0, D1);

        // Radix-16 digits, subtract.
        full_op(1, "sub_eq", 8'h3C, 8'h3C, 2'b01, 8'h00, D0, D1, D0);
        full_op(1, "sub_ovf", 8'h80, 8'h01, 2'b01, 8'h7F, D1, D0, D0);

        // Radix-4 digits, four back-to-back handshakes.
        full_op(2, "and", 8'hF0, 8'h3C, 2'b10, 8'h30, D0, D0, D0);
        full_op(2, "xor", 8'hF0, 8'h3C, 2'b11, 8'hCC, D0, D0, D1);
        full_op(2, "add_wrap", 8'hFF, 8'h01, 2'b00, 8'h00, D0, D1, D0);
        full_op(2, "sub_neg", 8'h10, 8'h20, 2'b01, 8'hF0, D0, D0, D1);

        // Partial DATA: pair 5 of b NULL for three cycles, then completed.
        start_op(1, 8'h12, 8'h34, 2'b00);
        b_v[1][11:10] = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("partial_ko", 32'(ko_v[1]), 32'd1);
        end
        full_op(1, "partial_done", 8'h12, 8'h34, 2'b00, 8'h46, D0, D0, D0);

        // Illegal pair on a[1:0]; then a legal op still completes, err sticks.
        start_op(0, 8'h5, 8'h3, 2'b00);
        a_v[0][1:0] = 2'b11;
        @(negedge clk);
        check("ill_err", 32'(err_v[0]), 32'd1);
        check("ill_ko", 32'(ko_v[0]), 32'd1);
        @(negedge clk);
        check("ill_hold_ko", 32'(ko_v[0]), 32'd1);
        check("ill_other_err", 32'(err_v[1]), 32'd0);
        start_op(0, 8'h3, 8'h5, 2'b01);
        wait_result(0, "ill_after", 8'hE, D0, D0, D1);
        check("ill_sticky", 32'(err_v[0]), 32'd1);
        release_op(0, "ill_after");

        // Reset mid-COMPUTE.
        start_op(1, 8'h55, 8'h0F, 2'b00);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstc_out", {10'd0, soma_v[1], of_v[1], zero_v[1], neg_v[1]}, 32'd0);
        check("rstc_ko", 32'(ko_v[1]), 32'd1);
        check("rstc_err", 32'(err_v[0]), 32'd0);
        a_v[1] = '0; b_v[1] = '0; opr_v[1] = '0;
        @(negedge clk);
        rst = 1'b0;
        full_op(1, "after_rstc", 8'h01, 8'h01, 2'b00, 8'h02, D0, D0, D0);

        // Reset while holding DATA with ki=1.
        start_op(1, 8'hFF, 8'hFF, 2'b00);
        wait_result(1, "pre_rsto", 8'hFE, D0, D0, D1);
        rst = 1'b1;
        #1;
        check("rsto_out", {10'd0, soma_v[1], of_v[1], zero_v[1], neg_v[1]}, 32'd0);
        check("rsto_ko", 32'(ko_v[1]), 32'd1);
        a_v[1] = '0; b_v[1] = '0; opr_v[1] = '0;
        @(negedge clk);
        rst = 1'b0;
        full_op(1, "after_rsto", 8'h05, 8'h03, 2'b01, 8'h02, D0, D0, D0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ncl_alu_seq.md
Name: ncl_alu_seq

Overview:
- Parametrised successor to the team's 4-bit dual-rail ALU: WIDTH-bit dual-rail add/sub/and/xor with signed overflow, zero and negative flags.
- Executes digit-serially, DIGIT bits per clock, LSB first, inside a clocked four-phase NULL/DATA wavefront handshake.
- Sits between dual-rail producer and consumer stages; lets wide ALUs be built from a small, reused digit slice.

Parameters:
- WIDTH, 8, operand width in bits; each bit is one dual-rail pair (2 wires).
- DIGIT, 1, bits processed per cycle; WIDTH % DIGIT == 0 is required, elaboration error otherwise.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- a  in  2*WIDTH  dual-rail operand A.
- b  in  2*WIDTH  dual-rail operand B.
- opr  in  4  dual-rail 2-bit opcode: 00 ADD, 01 SUB, 10 AND, 11 XOR.
- ki  in  1  downstream acknowledge: 1 = request DATA, 0 = request NULL.
- ko  out  1  upstream acknowledge, same encoding as ki.
- soma  out  2*WIDTH  dual-rail result.
- of  out  2  dual-rail signed overflow.
- zero  out  2  dual-rail result == 0.
- neg  out  2  dual-rail result MSB.
- err  out  1  single-rail, sticky illegal-code flag.

Behaviour:
- Encoding: pair i = {x[2i+1], x[2i]}; 00 NULL, 01 DATA0, 10 DATA1, 11 illegal. neg = soma[2W-1:2W-2].
- Input "complete DATA": every pair of a, b and opr is 01 or 10. Input "all NULL": every pair is 00.
- Reset (async, any state): state=WAIT_DATA, ko=1, soma/of/zero/neg=all NULL, err=0, digit counter=0, carry=0.
- FSM, all outputs registered:
  - WAIT_DATA: ko=1, outputs NULL. On complete DATA: latch a, b, opr as binary; carry=1 for SUB, else 0; go COMPUTE. Partial DATA (some NULL pairs): wait, nothing latched.
  - COMPUTE: ko=0. One digit per cycle for WIDTH/DIGIT cycles. SUB computes A + ~B + 1. Input changes are ignored here.
  - OUT_DATA: soma, of, zero and neg driven DATA. Stay while ki==1; on ki==0 go OUT_NULL.
  - OUT_NULL: outputs NULL, ko=0. When ki==1 and inputs all NULL, go WAIT_DATA.
- Latency: complete DATA sampled at edge t; result DATA appears after edge t+WIDTH/DIGIT+1. Throughput: one op per four-phase cycle.
- Flags:
  - of = carry into MSB XOR carry out, for ADD/SUB only; DATA0 for AND/XOR.
  - zero = DATA1 iff all result bits are 0.
  - neg = result MSB.
  - Unsigned carry out is not exported.
- Illegal pair (11) on any input in WAIT_DATA: err<=1, nothing latched, state held. err clears only on rst.
- ki==0 while in WAIT_DATA/COMPUTE: ignored; honoured only in OUT_DATA.
- Arithmetic wraps modulo 2^WIDTH.
- soma, of, zero and neg always change together on one edge. No mixed NULL/DATA output word ever appears.

Decomposition:
- Package ncl_pkg:
  - dual-rail constants NCL_NULL, NCL_D0, NCL_D1, NCL_ILL;
  - opcode constants OP_ADD, OP_SUB, OP_AND, OP_XOR;
  - state enum WAIT_DATA, COMPUTE, OUT_DATA, OUT_NULL;
  - functions to test a bus for complete DATA, all NULL and illegal pairs, and to encode/decode binary to/from dual-rail.
- Sub-module ncl_alu_digit: combinational DIGIT-bit slice with inputs a, b, op and carry-in; outputs result, carry-out and carry into the slice MSB, used for overflow on the last digit.
- Top holds the FSM, operand shift registers, digit counter and output registers.

Test Plan:
- WIDTH=4, DIGIT=1, ADD a=5 b=3 -> 5 cycles after capture: soma=1000 (DATA), of=DATA1, neg=DATA1, zero=DATA0. Then ki=0 -> NULL outputs; ki=1 plus NULL inputs -> ko=1.
- WIDTH=8, DIGIT=4, SUB a=0x3C b=0x3C -> result after 3 cycles: soma=0x00, zero=DATA1, of=DATA0. Repeat with a=0x80 b=0x01 -> 0x7F, of=DATA1, neg=DATA0.
- WIDTH=8, DIGIT=2, AND 0xF0/0x3C -> 0x30; XOR 0xF0/0x3C -> 0xCC, of=DATA0. Four back-to-back handshakes complete with no lost or duplicated result.
- Partial DATA held 3 cycles (b pair 5 NULL) -> no capture, ko stays 1. Then the pair completes -> capture on the next edge.
- Pair 11 on a[1:0] in WAIT_DATA -> err=1, state unchanged. After legal DATA the op completes normally and err stays 1.
- Assert rst mid-COMPUTE and again in OUT_DATA with ki held 1 -> immediate NULL outputs, ko=1, err=0. The next op's result is unaffected by stale carry.
